rf_envelope_demod: RTL and testbench
====================================

Name: rf_envelope_demod

Overview:
- Receive-side counterpart of the RF modulator output low-pass filter.
- Takes signed 7-bit AM/RF samples at the clk rate, full-wave rectifies them, and integrates-and-dumps over DECIM accepted samples.
- Outputs the decimated 6-bit envelope through a valid/ready register.
- Used for on-chip loopback checking of the modulator chain and as a baseband recovery stage.

Parameters:
- DECIM, 16, samples per output word; power of two, 2..256.
- LOG2_DECIM, 4, log2(DECIM); must match DECIM.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- x  input  7  signed RF sample, two's complement
- in_valid  input  1  x is valid this cycle; sample accepted whenever high (no backpressure on input)
- out_data  output  6  unsigned envelope average
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- overrun  output  1  sticky; a word was overwritten before being accepted
- peak  output  6  peak envelope (only with RF_DEMOD_PEAK_EN, else tied 0)

Behaviour:
- Reset values: out_data=0, out_valid=0, overrun=0, peak=0, accumulator=0, sample counter=0. Reset asserted mid-accumulation discards the partial sum; the next sample after reset is sample 0 of a fresh window.
- Rectify, combinational: r = |x|. x=-64 saturates to 63, so r is always 0..63.
- Accumulator: unsigned, 6+LOG2_DECIM bits. It cannot overflow, since 63*DECIM fits.
- Counter: LOG2_DECIM bits. It advances only on in_valid and wraps from DECIM-1 to 0.
- Non-dump valid sample (counter != DECIM-1): acc <= acc + r; counter <= counter + 1.
- Dump sample (counter == DECIM-1):
  - out_data <= (acc + r) >> LOG2_DECIM, truncating.
  - acc <= 0; counter <= 0; out_valid <= 1.
  - Latency: out_valid is high the cycle after the DECIM-th accepted sample.
- Cycles with in_valid=0 leave acc and counter unchanged.
- Handshake: out_valid && out_ready with no dump in the same cycle sets out_valid <= 0 next cycle. out_data holds its value.
- Dump while out_valid=1 and out_ready=0: the new word overwrites out_data, out_valid stays 1, overrun <= 1. overrun stays set until reset.
- Dump in the same cycle as a consumer accept: the old word is consumed, the new word loads, out_valid stays 1, no overrun.
- out_data must not change while out_valid=1 and out_ready=0 unless an overrun occurs.

Optional Feature:
- Macro: RF_DEMOD_PEAK_EN.
- Defined: peak tracks the maximum envelope.
  - On each dump, if new out_data > peak, then peak <= new out_data.
  - Otherwise peak <= peak-1, saturating at 0.
  - peak updates only on dumps and resets to 0.
- Not defined: no peak register is synthesized and peak is constant 0.

Test Plan (DECIM=16):
1. x=+20 with in_valid=1 for 16 cycles, out_ready=1 -> out_valid pulses one cycle, starting the cycle after the 16th sample, with out_data=20. overrun=0.
2. x alternating +40/-40 for 16 samples, then x=-64 for 16 samples -> words 40 then 63.
3. x=+10 with in_valid toggling 1,0,1,0 for 32 cycles -> exactly one word, out_data=10, after the 16th valid sample (cycle 31).
4. out_ready=0, 32 samples: x=+8 for the first 16, x=+30 for the next 16 -> after the second dump out_data=30, out_valid=1, overrun=1. Then out_ready=1 for one cycle -> out_valid=0; overrun stays 1.
5. 10 samples of x=+63, then reset for one cycle, then 16 samples of x=+5 -> out_data=5 (partial sum discarded). overrun=0, out_valid=0 during and right after reset.
6. With RF_DEMOD_PEAK_EN, out_ready=1: one window at +50, then three windows at x=0 -> peak sequence 50, 49, 48, 47. Without the macro, peak stays 0.

Source files
------------

// File: rtl/rf_envelope_demod.sv
// Full-wave rectifying integrate-and-dump envelope demodulator with a valid/ready output register.
// Optional peak-envelope tracker enabled by defining RF_DEMOD_PEAK_EN.
module rf_envelope_demod #(
  parameter int DECIM      = 16,
  parameter int LOG2_DECIM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] x,
  input  logic       in_valid,
  output logic [5:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic [5:0] peak
);

  localparam int ACC_W = 6 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] LAST_CNT = LOG2_DECIM'(DECIM - 1);

  logic [5:0]            r;
  logic [6:0]            x_neg;
  logic [ACC_W-1:0]      sum;
  logic                  dump;

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [5:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;

  // Rectifier: -64 has no positive 7-bit counterpart, so it clamps to 63.
  always_comb begin
    x_neg = -x;
    if (x == 7'h40)  r = 6'd63;
    else if (x[6])   r = x_neg[5:0];
    else             r = x[5:0];
  end

  assign sum  = acc_q + ACC_W'(r);
  assign dump = in_valid && (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (dump) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_data_d  = sum[ACC_W-1:LOG2_DECIM];
      out_valid_d = 1'b1;
      // A pending word that the consumer is not taking this cycle gets lost.
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else begin
      if (in_valid) begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

`ifdef RF_DEMOD_PEAK_EN
  logic [5:0] peak_q, peak_d;

  // Peak attacks instantly to a larger word and otherwise decays by one per dump.
  always_comb begin
    peak_d = peak_q;
    if (dump) begin
      if (out_data_d > peak_q)    peak_d = out_data_d;
      else if (peak_q != 6'd0)    peak_d = peak_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak = peak_q;
`else
  assign peak = 6'd0;
`endif

endmodule

// File: tb/tb_rf_envelope_demod.sv
// Self-checking bench for rf_envelope_demod (DECIM=16): window table plus handshake, overrun,
// reset and peak sequences; expected words are queued at drive time and popped on dump.
module tb_rf_envelope_demod;

  localparam int DECIM = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] x = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [5:0] out_data;
  logic       out_valid;
  logic       overrun;
  logic [5:0] peak;

  rf_envelope_demod #(.DECIM(DECIM), .LOG2_DECIM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .peak      (peak)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];
  int m_cnt, m_data, m_peak;
  bit m_valid, m_ovr;

  typedef struct {
    int xa;
    int xb;
    int word;
  } win_t;

  win_t vec[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_data = 0; m_peak = 0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock: drive, advance the reference model, then sample 1ns after the edge.
  task automatic step(input int xv, input bit v, input bit rdy);
    bit dmp;
    int w;
    x = 7'(xv); in_valid = v; out_ready = rdy;
    dmp = v && (m_cnt == DECIM - 1);
    w = 0;
    if (dmp) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard: dump with no expected word queued (t=%0t)", $time);
      end else begin
        w = exp_q.pop_front();
      end
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data = w;
      m_cnt = 0;
      if (w > m_peak)       m_peak = w;
      else if (m_peak != 0) m_peak = m_peak - 1;
    end else begin
      if (v) m_cnt++;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("overrun", int'(overrun), int'(m_ovr));
    check("out_data", int'(out_data), m_data);
`ifdef RF_DEMOD_PEAK_EN
    if (dmp) check("peak", int'(peak), m_peak);
`else
    check("peak_tied", int'(peak), 0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_peak", int'(peak), 0);
  endtask

  initial begin
    vec[0] = '{xa: 20,  xb: 20,  word: 20};
    vec[1] = '{xa: 40,  xb: -40, word: 40};
    vec[2] = '{xa: -64, xb: -64, word: 63};
    vec[3] = '{xa: 0,   xb: 0,   word: 0};
    vec[4] = '{xa: 63,  xb: -63, word: 63};
    vec[5] = '{xa: 1,   xb: 2,   word: 1};
    vec[6] = '{xa: -1,  xb: 0,   word: 0};
    vec[7] = '{xa: 31,  xb: 32,  word: 31};

    model_reset();
    do_reset();

    // Windows with out_ready=1: word appears the cycle after the 16th sample, then drops.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vec[i].word);
      for (int s = 0; s < DECIM; s++)
        step((s % 2 == 0) ? vec[i].xa : vec[i].xb, 1'b1, 1'b1);
    end
    step(0, 1'b0, 1'b1);

    // in_valid toggling: only valid cycles count toward the window.
    exp_q.push_back(10);
    for (int c = 0; c < 32; c++) step(10, (c % 2 == 0), 1'b1);
    step(0, 1'b0, 1'b1);

    // Back-pressure: second dump overwrites an unconsumed word.
    exp_q.push_back(8);
    for (int s = 0; s < DECIM; s++) step(8, 1'b1, 1'b0);
    exp_q.push_back(30);
    for (int s = 0; s < DECIM; s++) step(30, 1'b1, 1'b0);
    check("ovr_data", int'(out_data), 30);
    check("ovr_flag", int'(overrun), 1);
    step(0, 1'b0, 1'b1);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_drained", int'(out_valid), 0);

    // Dump coinciding with a consumer accept: no overrun, valid stays high.
    do_reset();
    exp_q.push_back(12);
    for (int s = 0; s < DECIM; s++) step(12, 1'b1, 1'b0);
    exp_q.push_back(7);
    for (int s = 0; s < DECIM - 1; s++) step(7, 1'b1, 1'b0);
    step(7, 1'b1, 1'b1);
    check("accept_dump_ovr", int'(overrun), 0);
    step(0, 1'b0, 1'b1);

    // Mid-window reset discards the partial sum.
    for (int s = 0; s < 10; s++) step(63, 1'b1, 1'b1);
    do_reset();
    exp_q.push_back(5);
    for (int s = 0; s < DECIM; s++) step(5, 1'b1, 1'b1);
    check("post_rst_word", int'(out_data), 5);
    step(0, 1'b0, 1'b1);

    // Peak: one loud window then three silent ones (50, 49, 48, 47 when enabled).
    do_reset();
    exp_q.push_back(50);
    for (int s = 0; s < DECIM; s++) step(50, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(0);
      for (int s = 0; s < DECIM; s++) step(0, 1'b1, 1'b1);
    end
`ifdef RF_DEMOD_PEAK_EN
    check("peak_final", int'(peak), 47);
`else
    check("peak_final", int'(peak), 0);
`endif
    step(0, 1'b0, 1'b1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
